// File: rtl/apb_slave_bridge_if.sv
// ---------------------------------------------------------------------------
// apb_slave_bridge_if
//   APB bus bundle between an APB requester (interconnect) and the
//   apb_slave_bridge completer front end.
//
//   Requester -> completer : psel, penable, pwrite, paddr, pwdata, pstrb
//   Completer -> requester : pready, prdata, pslverr
//
//   modport master : the interconnect / bus driver side
//   modport slave  : the bridge side
// ---------------------------------------------------------------------------
interface apb_slave_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_W-1:0]     paddr;
    logic [DATA_W-1:0]     pwdata;
    logic [DATA_W/8-1:0]   pstrb;
    logic                  pready;
    logic [DATA_W-1:0]     prdata;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_slave_bridge.sv
// ---------------------------------------------------------------------------
// apb_slave_bridge
//   APB completer front end for a peripheral register bank. A SETUP phase is
//   decoded and latched, optional wait states are inserted, then a single
//   request is presented to the register file over reg_req/reg_ready. The
//   APB response (PREADY for one cycle, PSLVERR, PRDATA) follows. Bad
//   addresses, misaligned addresses, writes to read-only registers and
//   register-file timeouts complete with PSLVERR and never reach the bank.
//
// Ports
//   clk        system clock (APB shares this domain)
//   rst        asynchronous reset, active-high
//   apb        APB bus (slave modport): psel/penable/pwrite/paddr/pwdata/
//              pstrb in, pready/prdata/pslverr out
//   reg_req    request to register file, held until reg_ready
//   reg_write  request is a write
//   reg_idx    register index
//   reg_wdata  write data
//   reg_wstrb  write byte strobes (all zeros on reads)
//   reg_ready  register file accepts request; read data valid this cycle
//   reg_rdata  read data, sampled on reg_req && reg_ready
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module apb_slave_bridge #(
    parameter int                  DATA_W      = 32,
    parameter int                  ADDR_W      = 32,
    parameter int                  NUM_REGS    = 8,
    parameter int                  BASE_ADDR   = 0,
    parameter int                  WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
    parameter int                  TIMEOUT     = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    apb_slave_bridge_if.slave           apb,
    output logic                        reg_req,
    output logic                        reg_write,
    output logic [$clog2(NUM_REGS)-1:0] reg_idx,
    output logic [DATA_W-1:0]           reg_wdata,
    output logic [DATA_W/8-1:0]         reg_wstrb,
    input  logic                        reg_ready,
    input  logic [DATA_W-1:0]           reg_rdata
);
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int TO_W   = $clog2(TIMEOUT + 1);
    // One counter serves both the wait-state phase and the timeout phase.
    localparam int CNT_W  = (TO_W > 4) ? TO_W : 4;

    localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);
    // One bit wider than the address so a bank ending at the top of the
    // address space still compares correctly.
    localparam logic [ADDR_W:0]   SPAN      = (ADDR_W + 1)'(NUM_REGS * STRB_W);
    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(WAIT_STATES - 1);
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ISSUE,
        S_RESP
    } state_t;

    state_t              state_q,   state_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic                err_q,     err_d;
    logic                abort_q,   abort_d;
    logic                req_q,     req_d;
    logic                write_q,   write_d;
    logic [IDX_W-1:0]    idx_q,     idx_d;
    logic [DATA_W-1:0]   wdata_q,   wdata_d;
    logic [STRB_W-1:0]   wstrb_q,   wstrb_d;
    logic                pready_q,  pready_d;
    logic                pslverr_q, pslverr_d;
    logic [DATA_W-1:0]   prdata_q,  prdata_d;

    // ------------------------------------------------------------------
    // Address decode of the SETUP phase
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0]   offset;
    logic                in_range;
    logic                misaligned;
    logic [IDX_W-1:0]    idx_calc;
    logic [NUM_REGS-1:0] ro_sel;
    logic                ro_hit;
    logic                err_calc;

    assign offset   = apb.paddr - BASE_A;
    assign in_range = (apb.paddr >= BASE_A) && ({1'b0, offset} < SPAN);
    assign idx_calc = offset[OFF_W +: IDX_W];

    if (OFF_W > 0) begin : g_align
        assign misaligned = |apb.paddr[OFF_W-1:0];
    end else begin : g_no_align
        assign misaligned = 1'b0;
    end

    // Decoded read-only lookup; an out-of-range index simply matches nothing
    // (the range error covers that case anyway).
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_ro
        assign ro_sel[gi] = RO_MASK[gi] && (idx_calc == IDX_W'(gi));
    end

    assign ro_hit   = apb.pwrite && (|ro_sel);
    assign err_calc = !in_range || misaligned || ro_hit;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            abort_q   <= 1'b0;
            req_q     <= 1'b0;
            write_q   <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            abort_q   <= abort_d;
            req_q     <= req_d;
            write_q   <= write_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state / registered outputs. The response outputs are computed
    // on the transition into S_RESP so they are valid for exactly the one
    // cycle spent there and default back to zero afterwards.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        abort_d   = abort_q;
        req_d     = req_q;
        write_d   = write_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;

        unique case (state_q)
            S_IDLE: begin
                // PENABLE without a preceding SETUP is ignored here.
                if (apb.psel && !apb.penable) begin
                    write_d = apb.pwrite;
                    idx_d   = idx_calc;
                    wdata_d = apb.pwdata;
                    wstrb_d = apb.pwrite ? apb.pstrb : '0;
                    err_d   = err_calc;
                    abort_d = 1'b0;
                    cnt_d   = '0;
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                    end else if (err_calc) begin
                        state_d   = S_RESP;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                        req_d   = 1'b1;
                    end
                end
            end

            S_WAIT: begin
                if (!apb.psel) begin
                    // Requester gave up before anything reached the bank.
                    state_d = S_IDLE;
                end else if (cnt_q == WAIT_LAST) begin
                    cnt_d = '0;
                    if (err_q) begin
                        state_d   = S_RESP;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                        req_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_ISSUE: begin
                cnt_d = cnt_q + 1'b1;
                // The request already in flight must complete; remember
                // that no APB response is wanted for it.
                if (!apb.psel) begin
                    abort_d = 1'b1;
                end
                if (reg_ready) begin
                    req_d = 1'b0;
                    cnt_d = '0;
                    if (abort_q || !apb.psel) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d  = S_RESP;
                        pready_d = 1'b1;
                        prdata_d = write_q ? '0 : reg_rdata;
                    end
                end else if ((TIMEOUT > 0) && (cnt_q == TO_LAST)) begin
                    req_d = 1'b0;
                    err_d = 1'b1;
                    cnt_d = '0;
                    if (abort_q || !apb.psel) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_RESP;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                    end
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign apb.pready  = pready_q;
    assign apb.pslverr = pslverr_q;
    assign apb.prdata  = prdata_q;
    assign reg_req     = req_q;
    assign reg_write   = write_q;
    assign reg_idx     = idx_q;
    assign reg_wdata   = wdata_q;
    assign reg_wstrb   = wstrb_q;
endmodule

// File: tb/tb_apb_slave_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb_slave_bridge
//   Three bridge instances share one set of APB/register-side stimulus:
//     dut 0: defaults
//     dut 1: WAIT_STATES=3
//     dut 2: RO_MASK=0x01, TIMEOUT=4
//   sel_dut routes PSEL to one instance and selects which outputs the
//   monitor observes. Stimulus pushes the expected response into exp_q; the
//   monitor pops and compares whenever PREADY is seen, and checks the
//   register request against the queue head when reg_req && reg_ready.
// ---------------------------------------------------------------------------
module tb_apb_slave_bridge;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // shared stimulus
    logic          psel      = 1'b0;
    logic          penable   = 1'b0;
    logic          pwrite    = 1'b0;
    logic [AW-1:0] paddr     = '0;
    logic [DW-1:0] pwdata    = '0;
    logic [SW-1:0] pstrb     = '0;
    logic          reg_ready = 1'b1;
    logic [DW-1:0] reg_rdata = '0;
    int            sel_dut   = 0;

    // per-instance outputs
    logic          o_pready  [3];
    logic          o_pslverr [3];
    logic [DW-1:0] o_prdata  [3];
    logic          o_req     [3];
    logic          o_wr      [3];
    logic [IW-1:0] o_idx     [3];
    logic [DW-1:0] o_wdata   [3];
    logic [SW-1:0] o_wstrb   [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        apb_slave_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

        assign bus.psel    = psel && (sel_dut == gi);
        assign bus.penable = penable;
        assign bus.pwrite  = pwrite;
        assign bus.paddr   = paddr;
        assign bus.pwdata  = pwdata;
        assign bus.pstrb   = pstrb;
        assign o_pready[gi]  = bus.pready;
        assign o_pslverr[gi] = bus.pslverr;
        assign o_prdata[gi]  = bus.prdata;

        apb_slave_bridge #(
            .DATA_W      (DW),
            .ADDR_W      (AW),
            .NUM_REGS    (8),
            .BASE_ADDR   (0),
            .WAIT_STATES ((gi == 1) ? 3 : 0),
            .RO_MASK     ((gi == 2) ? 8'h01 : 8'h00),
            .TIMEOUT     ((gi == 2) ? 4 : 0)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .apb       (bus),
            .reg_req   (o_req[gi]),
            .reg_write (o_wr[gi]),
            .reg_idx   (o_idx[gi]),
            .reg_wdata (o_wdata[gi]),
            .reg_wstrb (o_wstrb[gi]),
            .reg_ready (reg_ready),
            .reg_rdata (reg_rdata)
        );
    end

    logic          m_pready, m_pslverr, m_req, m_wr;
    logic [DW-1:0] m_prdata, m_wdata;
    logic [IW-1:0] m_idx;
    logic [SW-1:0] m_wstrb;
    always_comb begin
        m_pready  = o_pready[sel_dut];
        m_pslverr = o_pslverr[sel_dut];
        m_prdata  = o_prdata[sel_dut];
        m_req     = o_req[sel_dut];
        m_wr      = o_wr[sel_dut];
        m_idx     = o_idx[sel_dut];
        m_wdata   = o_wdata[sel_dut];
        m_wstrb   = o_wstrb[sel_dut];
    end

    // ------------------------------------------------------------------
    // scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        int            id;
        int            setup;
        int            lat;
        logic          err;
        logic [DW-1:0] rd;
        int            nreq;
        logic          wr;
        logic [IW-1:0] idx;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   errors   = 0;
    int   req_cnt  = 0;
    bit   idle_chk = 1'b0;
    int   last_id  = 0;
    int   next_id  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (idle_chk) begin
                chk($sformatf("t%0d_release_flags", last_id), 64'({m_pready, m_pslverr}), 64'd0);
                chk($sformatf("t%0d_release_prdata", last_id), 64'(m_prdata), 64'd0);
                idle_chk = 1'b0;
            end
            if (m_req) begin
                req_cnt++;
                if (reg_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_reg_req", 64'd1, 64'd0);
                    end else begin
                        mon_e = exp_q[0];
                        chk($sformatf("t%0d_reg_write", mon_e.id), 64'(m_wr), 64'(mon_e.wr));
                        chk($sformatf("t%0d_reg_idx", mon_e.id), 64'(m_idx), 64'(mon_e.idx));
                        chk($sformatf("t%0d_reg_wstrb", mon_e.id), 64'(m_wstrb), 64'(mon_e.wstrb));
                        if (mon_e.wr)
                            chk($sformatf("t%0d_reg_wdata", mon_e.id), 64'(m_wdata), 64'(mon_e.wdata));
                    end
                end
            end
            if (m_pready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pready", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk($sformatf("t%0d_latency", mon_e.id), 64'(cyc - mon_e.setup), 64'(mon_e.lat));
                    chk($sformatf("t%0d_pslverr", mon_e.id), 64'(m_pslverr), 64'(mon_e.err));
                    chk($sformatf("t%0d_prdata", mon_e.id), 64'(m_prdata), 64'(mon_e.rd));
                    chk($sformatf("t%0d_req_cycles", mon_e.id), 64'(req_cnt), 64'(mon_e.nreq));
                    last_id  = mon_e.id;
                    idle_chk = 1'b1;
                end
                req_cnt = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // stimulus
    // ------------------------------------------------------------------
    task automatic xfer(input int d, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [SW-1:0] st,
                        input logic [DW-1:0] rdval, input int lat, input logic err,
                        input logic [DW-1:0] exp_rd, input int nreq,
                        input logic [IW-1:0] exp_idx, input logic [SW-1:0] exp_wstrb);
        exp_t e;
        int   n;
        @(posedge clk); #1;
        sel_dut   = d;
        psel      = 1'b1;
        penable   = 1'b0;
        pwrite    = wr;
        paddr     = a;
        pwdata    = wd;
        pstrb     = st;
        reg_rdata = rdval;
        e.id    = next_id;
        e.setup = cyc;
        e.lat   = lat;
        e.err   = err;
        e.rd    = exp_rd;
        e.nreq  = nreq;
        e.wr    = wr;
        e.idx   = exp_idx;
        e.wdata = wd;
        e.wstrb = exp_wstrb;
        exp_q.push_back(e);
        next_id++;
        @(posedge clk); #1;
        penable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_pready && n < 40);
        if (!m_pready) begin
            chk($sformatf("t%0d_pready_timeout", e.id), 64'd0, 64'd1);
            void'(exp_q.pop_back());
        end
        @(posedge clk); #1;
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got %0d cycles expected fewer", cyc);
        $fatal(1);
    end

    initial begin
        int seen;

        // reset state of every instance
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            sel_dut = d;
            #1;
            chk($sformatf("rst%0d_pready", d),  64'(m_pready),  64'd0);
            chk($sformatf("rst%0d_pslverr", d), 64'(m_pslverr), 64'd0);
            chk($sformatf("rst%0d_prdata", d),  64'(m_prdata),  64'd0);
            chk($sformatf("rst%0d_reg_req", d), 64'(m_req),     64'd0);
            chk($sformatf("rst%0d_reg_write", d), 64'(m_wr),    64'd0);
            chk($sformatf("rst%0d_reg_idx", d), 64'(m_idx),     64'd0);
            chk($sformatf("rst%0d_reg_wdata", d), 64'(m_wdata), 64'd0);
            chk($sformatf("rst%0d_reg_wstrb", d), 64'(m_wstrb), 64'd0);
        end
        @(posedge clk); #1;
        rst     = 1'b0;
        sel_dut = 0;

        //   d  wr    addr    wdata          strb  rdval          lat err exp_rd        nreq idx  wstrb
        xfer(0, 1'b1, 32'h08, 32'hA5A5_0001, 4'hF, 32'h0,          2, 0, 32'h0,          1, 3'd2, 4'hF);
        xfer(0, 1'b0, 32'h08, 32'h0,         4'hF, 32'h0000_00C3,  2, 0, 32'h0000_00C3,  1, 3'd2, 4'h0);
        xfer(0, 1'b0, 32'h20, 32'h0,         4'h0, 32'hFFFF_FFFF,  1, 1, 32'h0,          0, 3'd0, 4'h0);
        xfer(0, 1'b0, 32'h06, 32'h0,         4'h0, 32'hFFFF_FFFF,  1, 1, 32'h0,          0, 3'd1, 4'h0);
        xfer(0, 1'b1, 32'h1C, 32'hDEAD_BEEF, 4'h0, 32'h0,          2, 0, 32'h0,          1, 3'd7, 4'h0);
        xfer(0, 1'b1, 32'h14, 32'h1122_3344, 4'h5, 32'h0,          2, 0, 32'h0,          1, 3'd5, 4'h5);
        xfer(1, 1'b0, 32'h04, 32'h0,         4'h0, 32'h1234_5678,  5, 0, 32'h1234_5678,  1, 3'd1, 4'h0);
        xfer(1, 1'b1, 32'h20, 32'h9999_0000, 4'hF, 32'h0,          4, 1, 32'h0,          0, 3'd0, 4'h0);
        xfer(2, 1'b1, 32'h00, 32'h5555_5555, 4'hF, 32'h0,          1, 1, 32'h0,          0, 3'd0, 4'h0);
        xfer(2, 1'b0, 32'h00, 32'h0,         4'h0, 32'hCAFE_F00D,  2, 0, 32'hCAFE_F00D,  1, 3'd0, 4'h0);
        xfer(2, 1'b1, 32'h04, 32'h0000_0077, 4'hF, 32'h0,          2, 0, 32'h0,          1, 3'd1, 4'hF);

        // register file never answers: request for 4 cycles, then error
        reg_ready = 1'b0;
        xfer(2, 1'b0, 32'h10, 32'h0,         4'h0, 32'h5A5A_5A5A,  5, 1, 32'h0,          4, 3'd4, 4'h0);
        reg_ready = 1'b1;

        // register file stalls two cycles before accepting
        reg_ready = 1'b0;
        fork
            xfer(0, 1'b0, 32'h0C, 32'h0,     4'h0, 32'h0BAD_BEEF,  4, 0, 32'h0BAD_BEEF,  3, 3'd3, 4'h0);
            begin
                repeat (4) @(posedge clk);
                #1 reg_ready = 1'b1;
            end
        join

        // PSEL dropped during the wait states: nothing reaches the bank
        @(posedge clk); #1;
        sel_dut = 1;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'h04;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel    = 1'b0;
        penable = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            seen += int'(m_pready) + int'(m_req);
        end
        chk("abort_in_wait_activity", 64'(seen), 64'd0);

        // PENABLE without SETUP is not a transfer
        @(posedge clk); #1;
        sel_dut = 0;
        psel    = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b1;
        paddr   = 32'h08;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            seen += int'(m_pready) + int'(m_req);
        end
        @(posedge clk); #1;
        psel    = 1'b0;
        penable = 1'b0;
        chk("penable_in_idle_activity", 64'(seen), 64'd0);

        // reset while the request is outstanding
        reg_ready = 1'b0;
        @(posedge clk); #1;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'h08;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        chk("rst_mid_req_before", 64'(m_req), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_req_dropped", 64'(m_req), 64'd0);
        chk("rst_mid_pready", 64'(m_pready), 64'd0);
        @(posedge clk); #1;
        rst       = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        reg_ready = 1'b1;
        req_cnt   = 0;

        xfer(0, 1'b1, 32'h18, 32'h0F0F_0F0F, 4'h3, 32'h0,          2, 0, 32'h0,          1, 3'd6, 4'h3);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
